// File: rtl/endstop_capture.sv
// Endstop trigger capture: arm/trigger FSM raising a motion abort,
// plus a FIFO logging every endstop edge with its position.
module endstop_capture #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          value,
  input  logic                          value_changed,
  input  logic [31:0]                   change_pos,
  input  logic                          polarity,
  input  logic                          arm,
  input  logic                          disarm,
  input  logic                          clear,
  output logic                          abort,
  output logic                          armed,
  output logic [31:0]                   trig_pos,
  output logic                          ev_valid,
  output logic [32:0]                   ev_data,
  input  logic                          ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          ev_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRIGGERED
  } state_t;

  state_t state;

  logic          active;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [32:0]   entry;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nx;
  logic [CW-1:0] count_nx;
  logic [32:0]   mem [FIFO_DEPTH];

  always_comb begin
    active = (value == polarity);
    entry  = {value, change_pos};
    pop    = ev_valid && ev_ready;
    full   = (ev_count == CW'(FIFO_DEPTH));
    push   = value_changed && (!full || pop);
    drop   = value_changed && full && !pop;
    rd_nx  = rd_ptr + AW'(1);
    count_nx = ev_count;
    if (push && !pop)
      count_nx = ev_count + CW'(1);
    else if (pop && !push)
      count_nx = ev_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      abort    <= 1'b0;
      armed    <= 1'b0;
      trig_pos <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          // disarm beats a simultaneous arm
          if (arm && !disarm) begin
            if (active) begin
              state    <= S_TRIGGERED;
              abort    <= 1'b1;
              trig_pos <= change_pos;
            end else begin
              state <= S_ARMED;
              armed <= 1'b1;
            end
          end
        end
        S_ARMED: begin
          if (value_changed && active) begin
            state    <= S_TRIGGERED;
            abort    <= 1'b1;
            armed    <= 1'b0;
            trig_pos <= change_pos;
          end else if (disarm) begin
            state <= S_IDLE;
            armed <= 1'b0;
          end
        end
        S_TRIGGERED: begin
          if (clear) begin
            state <= S_IDLE;
            abort <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          abort <= 1'b0;
          armed <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      ev_count    <= '0;
      ev_valid    <= 1'b0;
      ev_data     <= '0;
      ev_overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_nx;
      ev_count <= count_nx;
      ev_valid <= (count_nx != '0);
      // head register tracks the next entry to present
      if (pop) begin
        if (ev_count >= CW'(2))
          ev_data <= mem[rd_nx];
        else if (push)
          ev_data <= entry;
      end else if (ev_count == '0 && push) begin
        ev_data <= entry;
      end
      if (drop)
        ev_overflow <= 1'b1;
      else if (clear)
        ev_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_endstop_capture.sv
// Testbench for endstop_capture: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_endstop_capture;

  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          value = 1'b0;
  logic          value_changed = 1'b0;
  logic [31:0]   change_pos = '0;
  logic          polarity = 1'b1;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          clear = 1'b0;
  logic          abort;
  logic          armed;
  logic [31:0]   trig_pos;
  logic          ev_valid;
  logic [32:0]   ev_data;
  logic          ev_ready = 1'b0;
  logic [CW-1:0] ev_count;
  logic          ev_overflow;

  int n_checks = 0;
  int n_fail = 0;

  int          m_state;
  logic [31:0] m_trig;
  logic [32:0] q[$];
  logic [32:0] m_head;
  logic        m_ovf;

  endstop_capture #(.FIFO_DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .value_changed(value_changed),
    .change_pos(change_pos),
    .polarity(polarity),
    .arm(arm),
    .disarm(disarm),
    .clear(clear),
    .abort(abort),
    .armed(armed),
    .trig_pos(trig_pos),
    .ev_valid(ev_valid),
    .ev_data(ev_data),
    .ev_ready(ev_ready),
    .ev_count(ev_count),
    .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;

  // 0 = idle, 1 = armed, 2 = triggered
  task automatic model_update();
    logic act;
    logic drop;
    act = (value == polarity);
    if (reset) begin
      m_state = 0;
      m_trig  = '0;
      q.delete();
      m_head  = '0;
      m_ovf   = 1'b0;
    end else begin
      case (m_state)
        0: if (arm && !disarm) begin
          if (act) begin
            m_state = 2;
            m_trig  = change_pos;
          end else begin
            m_state = 1;
          end
        end
        1: if (value_changed && act) begin
          m_state = 2;
          m_trig  = change_pos;
        end else if (disarm) begin
          m_state = 0;
        end
        default: if (clear) m_state = 0;
      endcase
      drop = 1'b0;
      if (ev_ready && q.size() > 0)
        void'(q.pop_front());
      if (value_changed) begin
        if (q.size() < D)
          q.push_back({value, change_pos});
        else
          drop = 1'b1;
      end
      if (drop)
        m_ovf = 1'b1;
      else if (clear)
        m_ovf = 1'b0;
      if (q.size() > 0)
        m_head = q[0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    reset = 1'b0;
    value_changed = 1'b0;
    arm = 1'b0;
    disarm = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    value_changed = 1'b1;
    change_pos = 32'hDEAD;
    step();
    n_checks++;
    if ({abort, armed, trig_pos} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_fsm: got %b %b %h want 0 0 0", abort, armed, trig_pos);
    end
    n_checks++;
    if ({ev_valid, ev_data, ev_count, ev_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_fifo: got v=%b d=%h c=%0d o=%b want all 0",
               ev_valid, ev_data, ev_count, ev_overflow);
    end
  endtask

  task automatic test_trigger();
    polarity = 1'b1;
    value = 1'b0;
    arm = 1'b1;
    step();
    n_checks++;
    if (armed !== 1'b1 || abort !== 1'b0) begin
      n_fail++;
      $display("FAIL arm: got armed=%b abort=%b want 1 0", armed, abort);
    end
    value = 1'b1;
    value_changed = 1'b1;
    change_pos = 32'h1234;
    step();
    n_checks++;
    if (abort !== 1'b1 || trig_pos !== 32'h1234 || armed !== 1'b0) begin
      n_fail++;
      $display("FAIL trigger: got abort=%b pos=%h armed=%b want 1 1234 0",
               abort, trig_pos, armed);
    end
    n_checks++;
    if (ev_valid !== 1'b1 || ev_data !== {1'b1, 32'h1234}) begin
      n_fail++;
      $display("FAIL trig_event: got v=%b d=%h want 1 101234", ev_valid, ev_data);
    end
    ev_ready = 1'b1;
    clear = 1'b1;
    step();
    ev_ready = 1'b0;
    n_checks++;
    if (abort !== 1'b0 || ev_valid !== 1'b0 || trig_pos !== 32'h1234) begin
      n_fail++;
      $display("FAIL trig_clear: got abort=%b v=%b pos=%h want 0 0 1234",
               abort, ev_valid, trig_pos);
    end
  endtask

  task automatic test_arm_active();
    polarity = 1'b0;
    value = 1'b0;
    change_pos = 32'h55;
    arm = 1'b1;
    step();
    n_checks++;
    if (abort !== 1'b1 || armed !== 1'b0 || trig_pos !== 32'h55) begin
      n_fail++;
      $display("FAIL arm_active: got abort=%b armed=%b pos=%h want 1 0 55",
               abort, armed, trig_pos);
    end
    clear = 1'b1;
    step();
  endtask

  task automatic test_disarm_race();
    polarity = 1'b1;
    value = 1'b0;
    arm = 1'b1;
    disarm = 1'b1;
    step();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL arm_disarm_idle: got armed=%b want 0", armed);
    end
    arm = 1'b1;
    step();
    value = 1'b1;
    value_changed = 1'b1;
    disarm = 1'b1;
    change_pos = 32'hABCD;
    step();
    n_checks++;
    if (abort !== 1'b1 || trig_pos !== 32'hABCD) begin
      n_fail++;
      $display("FAIL disarm_race: got abort=%b pos=%h want 1 abcd", abort, trig_pos);
    end
    value = 1'b0;
    value_changed = 1'b1;
    change_pos = 32'h9999;
    arm = 1'b1;
    step();
    n_checks++;
    if (abort !== 1'b1 || trig_pos !== 32'hABCD) begin
      n_fail++;
      $display("FAIL trig_hold: got abort=%b pos=%h want 1 abcd", abort, trig_pos);
    end
    clear = 1'b1;
    ev_ready = 1'b1;
    step();
    step();
    ev_ready = 1'b0;
    n_checks++;
    if (abort !== 1'b0 || trig_pos !== 32'hABCD || ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL race_clear: got abort=%b pos=%h v=%b want 0 abcd 0",
               abort, trig_pos, ev_valid);
    end
  endtask

  task automatic test_overflow();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      value = 1'(i & 1);
      value_changed = 1'b1;
      change_pos = 32'h100 + 32'(i);
      step();
    end
    n_checks++;
    if (ev_count !== CW'(D) || ev_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got count=%0d ovf=%b want 4 1", ev_count, ev_overflow);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ev_valid !== 1'b1 || ev_data !== {1'(i & 1), 32'h100 + 32'(i)}) begin
        n_fail++;
        $display("FAIL ovf_order%0d: got v=%b d=%h want 1 %h", i, ev_valid,
                 ev_data, {1'(i & 1), 32'h100 + 32'(i)});
      end
      step();
    end
    ev_ready = 1'b0;
    clear = 1'b1;
    step();
    n_checks++;
    if (ev_valid !== 1'b0 || ev_count !== '0 || ev_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got v=%b c=%0d o=%b want 0 0 0",
               ev_valid, ev_count, ev_overflow);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) begin
      value_changed = 1'b1;
      change_pos = 32'h200 + 32'(i);
      value = 1'b1;
      step();
    end
    value_changed = 1'b1;
    change_pos = 32'h204;
    ev_ready = 1'b1;
    step();
    n_checks++;
    if (ev_count !== CW'(D) || ev_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop: got count=%0d ovf=%b want 4 0", ev_count, ev_overflow);
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (ev_data !== {1'b1, 32'h200 + 32'(i)}) begin
        n_fail++;
        $display("FAIL pushpop_order%0d: got %h want %h", i, ev_data,
                 {1'b1, 32'h200 + 32'(i)});
      end
      step();
    end
    ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    polarity = 1'b1;
    value = 1'b1;
    arm = 1'b1;
    change_pos = 32'h77;
    step();
    for (int i = 0; i < 3; i++) begin
      value_changed = 1'b1;
      change_pos = 32'h300 + 32'(i);
      step();
    end
    n_checks++;
    if (abort !== 1'b1 || ev_count !== CW'(3)) begin
      n_fail++;
      $display("FAIL pre_reset: got abort=%b count=%0d want 1 3", abort, ev_count);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (abort !== 1'b0 || ev_valid !== 1'b0 || ev_count !== '0 || trig_pos !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got abort=%b v=%b c=%0d pos=%h want 0 0 0 0",
               abort, ev_valid, ev_count, trig_pos);
    end
  endtask

  task automatic test_random();
    logic [38:0] got;
    logic [38:0] want;
    reset = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      value_changed = ($urandom_range(0, 2) == 0);
      value = value_changed ? 1'($urandom) : value;
      change_pos = $urandom;
      if ($urandom_range(0, 29) == 0)
        polarity = ~polarity;
      arm = ($urandom_range(0, 5) == 0);
      disarm = ($urandom_range(0, 7) == 0);
      clear = ($urandom_range(0, 11) == 0);
      ev_ready = ($urandom_range(0, 2) == 0);
      step();
      want = {m_state == 2, m_state == 1, m_trig, q.size() != 0};
      got = {abort, armed, trig_pos, ev_valid};
      n_checks++;
      if (got !== want || ev_data !== m_head || ev_count !== CW'(q.size())
          || ev_overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL random%0d: got %h d=%h c=%0d o=%b want %h d=%h c=%0d o=%b",
                 i, got, ev_data, ev_count, ev_overflow, want, m_head,
                 q.size(), m_ovf);
      end
    end
    ev_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_trigger();
    test_arm_active();
    test_disarm_race();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/endstop_capture.md
ENDSTOP_CAPTURE -- requirements
Module: endstop_capture

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port value  input  1  debounced endstop level.
REQ-005 SHALL have port value_changed  input  1  one-cycle strobe; value just changed.
REQ-006 SHALL have port change_pos  input  32  position at start of the change, valid with value_changed.
REQ-007 SHALL have port polarity  input  1  active level of endstop (1 = high means hit).
REQ-008 SHALL have port arm  input  1  one-cycle arm request.
REQ-009 SHALL have port disarm  input  1  one-cycle disarm request.
REQ-010 SHALL have port clear  input  1  one-cycle trigger/overflow clear.
REQ-011 SHALL have port abort  output  1  registered motion-abort request.
REQ-012 SHALL have port armed  output  1  high in S_ARMED.
REQ-013 SHALL have port trig_pos  output  32  latched trigger position.
REQ-014 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-015 SHALL have port ev_data  output  33  head entry {level, pos}, first-word-fall-through.
REQ-016 SHALL have port ev_ready  input  1  pop head when ev_valid high.
REQ-017 SHALL have port ev_count  output  clog2(FIFO_DEPTH)+1  entries stored.
REQ-018 SHALL have port ev_overflow  output  1  sticky; an event was dropped.

Function
REQ-019 SHALL define active = (value == polarity), evaluated on registered inputs of the current cycle.
REQ-020 SHALL implement states S_IDLE, S_ARMED, S_TRIGGERED; all outputs registered.
REQ-021 S_IDLE: arm with active low -> S_ARMED; arm with active high -> S_TRIGGERED, trig_pos <= change_pos input that cycle.
REQ-022 S_ARMED: value_changed with new value active -> S_TRIGGERED, trig_pos <= change_pos; disarm -> S_IDLE.
REQ-023 S_ARMED: disarm and trigger in same cycle -> trigger wins (S_TRIGGERED).
REQ-024 S_IDLE: arm and disarm in same cycle -> disarm wins, stay S_IDLE.
REQ-025 abort SHALL be high exactly while in S_TRIGGERED, first high the cycle after the triggering value_changed (1-cycle latency).
REQ-026 S_TRIGGERED: clear -> S_IDLE; arm/disarm ignored; further value_changed does not modify trig_pos.
REQ-027 trig_pos SHALL hold its value after leaving S_TRIGGERED until next trigger or reset.
REQ-028 Every value_changed SHALL push {value, change_pos} into the FIFO regardless of state.
REQ-029 Pop SHALL occur when ev_valid && ev_ready; ev_valid/ev_data update the following cycle.
REQ-030 Push into empty FIFO SHALL give ev_valid high the next cycle with that entry on ev_data.
REQ-031 Push when full without pop SHALL drop the new entry and set ev_overflow; push and pop in same cycle when full SHALL both succeed, ev_count unchanged.
REQ-032 Push and pop in same cycle when non-full, non-empty SHALL leave ev_count unchanged.
REQ-033 clear SHALL also reset ev_overflow, in any state; a drop in the same cycle as clear SHALL leave ev_overflow set.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH; ev_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-035 reset SHALL force S_IDLE, abort=0, armed=0, trig_pos=0, ev_valid=0, ev_data=0, ev_count=0, ev_overflow=0, overriding all other inputs including value_changed that cycle.
REQ-036 reset mid-trigger SHALL drop abort the cycle after reset is sampled; FIFO contents discarded.

Verification
REQ-037 polarity=1, value=0, arm; then value=1, value_changed, change_pos=0x1234 -> abort=1 next cycle, trig_pos=0x1234, ev_data={1,0x1234}.
REQ-038 polarity=0, value=0 at arm -> S_TRIGGERED immediately, abort=1 next cycle, armed=0.
REQ-039 In S_ARMED, disarm and triggering value_changed same cycle -> abort=1; then clear -> abort=0 next cycle, trig_pos retained.
REQ-040 FIFO_DEPTH=4, ev_ready=0, 5 value_changed strobes -> ev_count=4, ev_overflow=1, first 4 positions read back in order.
REQ-041 FIFO full, ev_ready=1 and value_changed same cycle -> ev_count stays 4, no overflow, order preserved.
REQ-042 reset asserted while abort=1 and FIFO holding 3 entries -> next cycle abort=0, ev_valid=0, ev_count=0.
